// File: rtl/seq_divider64by32.sv
// seq_divider64by32: iterative restoring divider, 2*WIDTH-bit dividend by
// WIDTH-bit divisor, one quotient bit per clock, start/done handshake.
// Optional macro DIV_SIGNED_EN adds a two's-complement mode (is_signed=1)
// with a FIX cycle after the magnitude division.
module seq_divider64by32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    input  logic               is_signed,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_by_zero,
    output logic               overflow
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
`ifdef DIV_SIGNED_EN
        S_FIX  = 2'd2,
`endif
        S_DONE = 2'd3
    } state_t;

    state_t               state;
    logic [WIDTH:0]       part_rem;
    logic [WIDTH-1:0]     q_sr;
    logic [WIDTH-1:0]     dvsr;
    logic [CW-1:0]        cnt;

    logic                 accept;
    logic [2*WIDTH-1:0]   dvd_mag;
    logic [WIDTH-1:0]     dvs_mag;
    logic [WIDTH:0]       shifted;
    logic [WIDTH:0]       trial;
    logic                 q_bit;
    logic [WIDTH:0]       r_next;
    logic [WIDTH-1:0]     q_next;

`ifdef DIV_SIGNED_EN
    localparam logic [WIDTH-1:0] Q_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    logic                 op_signed;
    logic                 sign_dvd;
    logic                 sign_dvs;
    logic                 neg_q;
    logic                 fix_ovf;
`else
    logic                 is_signed_unused;
    assign is_signed_unused = is_signed;
`endif

    assign accept = start && ((state == S_IDLE) || (state == S_DONE));

    // Operand magnitudes for the accept-edge pre-check and datapath load
    always_comb begin
        dvd_mag = dividend;
        dvs_mag = divisor;
`ifdef DIV_SIGNED_EN
        if (is_signed) begin
            if (dividend[2*WIDTH-1]) dvd_mag = -dividend;
            if (divisor[WIDTH-1])    dvs_mag = -divisor;
        end
`endif
    end

    // Restoring trial subtraction; bit WIDTH of the difference is the borrow
    always_comb begin
        shifted = {part_rem[WIDTH-1:0], q_sr[WIDTH-1]};
        trial   = shifted - {1'b0, dvsr};
        q_bit   = ~trial[WIDTH];
        r_next  = q_bit ? trial : shifted;
        q_next  = {q_sr[WIDTH-2:0], q_bit};
    end

`ifdef DIV_SIGNED_EN
    // Sign correction and signed-range check for the FIX cycle
    always_comb begin
        neg_q   = sign_dvd ^ sign_dvs;
        fix_ovf = (q_sr > Q_MIN) || ((q_sr == Q_MIN) && !neg_q);
    end
`endif

    // Control FSM with registered outputs and the iteration datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            part_rem    <= '0;
            q_sr        <= '0;
            dvsr        <= '0;
            cnt         <= '0;
`ifdef DIV_SIGNED_EN
            op_signed   <= 1'b0;
            sign_dvd    <= 1'b0;
            sign_dvs    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (accept) begin
                div_by_zero <= 1'b0;
                overflow    <= 1'b0;
                dvsr        <= dvs_mag;
`ifdef DIV_SIGNED_EN
                op_signed   <= is_signed;
                sign_dvd    <= is_signed & dividend[2*WIDTH-1];
                sign_dvs    <= is_signed & divisor[WIDTH-1];
`endif
                if (dvs_mag == '0) begin
                    div_by_zero <= 1'b1;
                    quotient    <= '1;
                    remainder   <= dividend[WIDTH-1:0];
                    state       <= S_DONE;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                end else if (dvd_mag[2*WIDTH-1:WIDTH] >= dvs_mag) begin
                    overflow    <= 1'b1;
                    quotient    <= '1;
                    remainder   <= dividend[WIDTH-1:0];
                    state       <= S_DONE;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                end else begin
                    part_rem    <= {1'b0, dvd_mag[2*WIDTH-1:WIDTH]};
                    q_sr        <= dvd_mag[WIDTH-1:0];
                    cnt         <= CW'(WIDTH - 1);
                    state       <= S_RUN;
                    busy        <= 1'b1;
                end
            end else begin
                case (state)
                    S_RUN: begin
                        part_rem <= r_next;
                        q_sr     <= q_next;
                        cnt      <= cnt - 1'b1;
                        if (cnt == '0) begin
`ifdef DIV_SIGNED_EN
                            if (op_signed) begin
                                state <= S_FIX;
                            end else
`endif
                            begin
                                quotient  <= q_next;
                                remainder <= r_next[WIDTH-1:0];
                                state     <= S_DONE;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                            end
                        end
                    end
`ifdef DIV_SIGNED_EN
                    S_FIX: begin
                        if (fix_ovf) begin
                            overflow <= 1'b1;
                            quotient <= Q_MIN;
                        end else begin
                            quotient <= neg_q ? -q_sr : q_sr;
                        end
                        remainder <= sign_dvd ? -part_rem[WIDTH-1:0] : part_rem[WIDTH-1:0];
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
`endif
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_divider64by32.sv
// tb_seq_divider64by32: directed vector table plus hand-written sequences for
// reset mid-operation, random multiply/divide round trips and back-to-back starts.
module tb_seq_divider64by32;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] dividend;
    logic [31:0] divisor;
    logic        is_signed;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;
    logic        overflow;

    int unsigned total;
    int unsigned bad;

    seq_divider64by32 #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .is_signed   (is_signed),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] dvd;
        logic [31:0] dvs;
        logic        sgn;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ov;
        int unsigned lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One transaction from IDLE: returns results, latency in cycles after the
    // accept edge, number of busy cycles before done, and a shape flag covering
    // busy low at done, done one cycle wide and results held afterwards.
    task automatic run_op(input logic [63:0] dvd, input logic [31:0] dvs, input logic sgn,
                          output logic [31:0] q, output logic [31:0] r,
                          output logic dz, output logic ov,
                          output int unsigned lat, output int unsigned bcnt,
                          output logic shape_ok);
        @(negedge clk);
        dividend  = dvd;
        divisor   = dvs;
        is_signed = sgn;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
        dividend  = {$urandom, $urandom};
        divisor   = $urandom;
        is_signed = ~sgn;
        lat  = 1;
        bcnt = 0;
        while (!done && lat < 60) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        q  = quotient;
        r  = remainder;
        dz = div_by_zero;
        ov = overflow;
        shape_ok = done && !busy;
        @(negedge clk);
        shape_ok = shape_ok && !done && (quotient === q) && (remainder === r);
    endtask

    initial begin : main
        logic [31:0] q, r, a, b, rr;
        logic        dz, ov, ok;
        int unsigned lat, bcnt, seen, k, prev_done;
        logic [63:0] prod;
        vec_t        ops[3];

        total = 0;
        bad   = 0;
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0; is_signed = 1'b0;

        // Reset state
        #12;
        check("reset_outputs", {busy, done, quotient, remainder, div_by_zero, overflow}, '0);
        @(negedge clk);
        rst = 1'b0;

        vecs.push_back('{64'h0000_0001_0000_0000, 32'h0000_0003, 1'b0, 32'h5555_5555, 32'h0000_0001, 1'b0, 1'b0, 33});
        vecs.push_back('{64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 33});
        vecs.push_back('{64'd1000,                32'd7,         1'b0, 32'd142,       32'd6,         1'b0, 1'b0, 33});
        vecs.push_back('{64'h0000_0000_0000_1234, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 1'b0, 1});
        vecs.push_back('{64'h0000_0005_0000_0000, 32'h0000_0005, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 1});
        vecs.push_back('{64'h0000_0000_0000_0000, 32'h0000_0001, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 33});
        vecs.push_back('{64'h0000_0000_FFFF_FFFF, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 33});
        vecs.push_back('{64'h1234_5678_9ABC_DEF0, 32'h1234_5678, 1'b0, 32'hFFFF_FFFF, 32'h9ABC_DEF0, 1'b0, 1'b1, 1});
        vecs.push_back('{64'h1234_5677_FFFF_FFFF, 32'h1234_5678, 1'b0, 32'hFFFF_FFFF, 32'h1234_5677, 1'b0, 1'b0, 33});
        vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1});
        vecs.push_back('{64'd100,                 32'd200,       1'b0, 32'd0,         32'd100,       1'b0, 1'b0, 33});
        vecs.push_back('{64'h0000_0000_8000_0000, 32'h0000_0002, 1'b0, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0, 33});
`ifdef DIV_SIGNED_EN
        vecs.push_back('{64'hFFFF_FFFF_FFFF_FFF9, 32'h0000_0002, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 34});
        vecs.push_back('{64'hFFFF_FFFF_8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b1, 34});
        vecs.push_back('{64'hFFFF_FFFF_FFFF_FFF9, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 1'b0, 1});
        vecs.push_back('{64'd1000,                32'd7,         1'b1, 32'd142,       32'd6,         1'b0, 1'b0, 34});
`else
        vecs.push_back('{64'hFFFF_FFFF_FFFF_FFF9, 32'h0000_0002, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0, 1'b1, 1});
        vecs.push_back('{64'd1000,                32'd7,         1'b1, 32'd142,       32'd6,         1'b0, 1'b0, 33});
`endif

        foreach (vecs[i]) begin
            run_op(vecs[i].dvd, vecs[i].dvs, vecs[i].sgn, q, r, dz, ov, lat, bcnt, ok);
            check($sformatf("vec%0d_result", i), {q, r, dz, ov},
                  {vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].ov});
            check($sformatf("vec%0d_latency", i), 128'(lat), 128'(vecs[i].lat));
            check($sformatf("vec%0d_busy_cycles", i), 128'(bcnt), 128'(vecs[i].lat - 1));
            check($sformatf("vec%0d_done_shape", i), 128'(ok), 128'(1));
        end

        // Reset in the middle of a run: outputs clear at once, no done pulse
        @(negedge clk);
        dividend = 64'd1000; divisor = 32'd7; is_signed = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_midrun_outputs", {busy, done, quotient, remainder, div_by_zero, overflow}, '0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check("rst_midrun_no_done", 128'(seen), 128'(0));
        run_op(64'd1000, 32'd7, 1'b0, q, r, dz, ov, lat, bcnt, ok);
        check("after_rst_result", {q, r, dz, ov, 32'(lat)}, {32'd142, 32'd6, 1'b0, 1'b0, 32'd33});

        // Multiply/divide round trip
        for (int i = 0; i < 2000; i++) begin
            a = $urandom;
            b = $urandom;
            if (b == 32'd0) b = 32'd1;
            rr   = $urandom % b;
            prod = 64'(a) * 64'(b) + 64'(rr);
            run_op(prod, b, 1'b0, q, r, dz, ov, lat, bcnt, ok);
            check($sformatf("rand%0d", i), {q, r, dz, ov, 32'(lat)}, {a, rr, 1'b0, 1'b0, 32'd33});
        end

        // Back-to-back with start held high; operands while busy are garbage
        ops[0] = '{64'd1000,                32'd7,         1'b0, 32'd142,       32'd6,         1'b0, 1'b0, 33};
        ops[1] = '{64'h0000_0001_0000_0000, 32'h0000_0003, 1'b0, 32'h5555_5555, 32'h0000_0001, 1'b0, 1'b0, 33};
        ops[2] = '{64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 33};
        @(negedge clk);
        dividend = ops[0].dvd; divisor = ops[0].dvs; is_signed = 1'b0; start = 1'b1;
        @(posedge clk);
        k = 0;
        prev_done = 0;
        for (int cyc = 1; cyc <= 120; cyc++) begin
            @(negedge clk);
            if (done) begin
                if (prev_done != 0) check("b2b_done_width", 128'(cyc), 128'(0));
                if (k < 3) begin
                    check($sformatf("b2b%0d_time", k), 128'(cyc), 128'(33 * (k + 1)));
                    check($sformatf("b2b%0d_result", k), {quotient, remainder, div_by_zero, overflow},
                          {ops[k].q, ops[k].r, 1'b0, 1'b0});
                end
                k++;
                if (k < 3) begin
                    dividend = ops[k].dvd;
                    divisor  = ops[k].dvs;
                end else begin
                    start = 1'b0;
                end
            end else if (start) begin
                dividend = {$urandom, $urandom};
                divisor  = $urandom_range(3, 0);
            end
            prev_done = done ? 1 : 0;
        end
        check("b2b_count", 128'(k), 128'(3));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
